// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: single-beat bus request with ack wait, timeout and misalignment detection.
// ALU ops pass straight through; loads/stores stall the pipe from IDLE through WAIT and retire in DONE.
module mem_access_stage #(
    parameter int ASIZE   = 5,
    parameter int DSIZE   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [ASIZE-1:0] waddr_in,
    input  logic [DSIZE-1:0] aluout_in,
    input  logic [DSIZE-1:0] wdata_in,
    input  logic             wen_in,
    input  logic             memtoreg_in,
    input  logic             memwrite_in,
    input  logic             flush,
    output logic             stall,
    output logic [ASIZE-1:0] waddr_out,
    output logic [DSIZE-1:0] result_out,
    output logic             wen_out,
    output logic             memtoreg_out,
    output logic             mem_req,
    output logic             mem_we,
    output logic [DSIZE-1:0] mem_addr,
    output logic [DSIZE-1:0] mem_wdata,
    input  logic             mem_ack,
    input  logic [DSIZE-1:0] mem_rdata,
    output logic             err_misalign,
    output logic             err_timeout,
    output logic [1:0]       state_dbg
);

    // Bus handshake: mem_req is held high for every WAIT cycle; the transfer
    // completes in the first cycle mem_req & mem_ack are both high. Address,
    // data and direction are registered on entry to WAIT and stay stable.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = 8;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic             kill;
    logic [DSIZE-1:0] rdata_q;
    logic [DSIZE-1:0] addr_q;
    logic [DSIZE-1:0] wdata_q;
    logic             mem_we_q;
    logic [ASIZE-1:0] waddr_q;
    logic             wen_q;
    logic             memtoreg_q;

    logic memop;
    logic misalign;
    logic capture;
    logic timeout_hit;

    assign memop       = valid_in & (memtoreg_in | memwrite_in) & ~flush;
    assign misalign    = memop & (aluout_in[1:0] != 2'b00);
    assign capture     = (state == IDLE) & memop & ~misalign;
    // mem_ack takes priority over an expiring counter in the same cycle
    assign timeout_hit = (state == WAIT) & ~mem_ack & (cnt == CW'(TIMEOUT - 1));

    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            kill       <= 1'b0;
            rdata_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mem_we_q   <= 1'b0;
            waddr_q    <= '0;
            wen_q      <= 1'b0;
            memtoreg_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                addr_q     <= aluout_in;
                wdata_q    <= wdata_in;
                mem_we_q   <= memwrite_in;
                waddr_q    <= waddr_in;
                wen_q      <= wen_in;
                memtoreg_q <= memtoreg_in;
                cnt        <= '0;
                kill       <= 1'b0;
            end
            if (state == WAIT) begin
                if (mem_ack) begin
                    rdata_q <= mem_rdata;
                end else if (timeout_hit) begin
                    rdata_q <= '0;
                    kill    <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                // a flush only suppresses writeback; the bus transfer still finishes
                if (flush) begin
                    kill <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        stall        = 1'b0;
        mem_req      = 1'b0;
        err_misalign = 1'b0;
        err_timeout  = 1'b0;
        waddr_out    = '0;
        result_out   = '0;
        wen_out      = 1'b0;
        memtoreg_out = 1'b0;

        case (state)
            IDLE: begin
                waddr_out    = waddr_in;
                result_out   = aluout_in;
                memtoreg_out = memtoreg_in;
                wen_out      = valid_in & wen_in & ~flush & ~memop;
                err_misalign = misalign;
                stall        = capture;
                if (capture) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                mem_req     = 1'b1;
                stall       = 1'b1;
                waddr_out   = waddr_q;
                err_timeout = timeout_hit;
                if (mem_ack | timeout_hit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                waddr_out    = waddr_q;
                memtoreg_out = memtoreg_q;
                wen_out      = wen_q & ~kill & ~flush;
                result_out   = memtoreg_q ? rdata_q : addr_q;
                state_nxt    = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (rst) begin
            stall        = 1'b0;
            mem_req      = 1'b0;
            err_misalign = 1'b0;
            err_timeout  = 1'b0;
            waddr_out    = '0;
            result_out   = '0;
            wen_out      = 1'b0;
            memtoreg_out = 1'b0;
        end
    end

endmodule
